// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the single register-file write port.
// Each requester owns a one-entry slot; slots drain oldest first and pending data is forwarded.
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              we3,
    output logic [ADDR_W-1:0] a3,
    output logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data,
    output logic [1:0]        pending
);

    logic [1:0]        r_full;
    logic [ADDR_W-1:0] r_addr [2];
    logic [DATA_W-1:0] r_data [2];
    logic              r_older;
    logic              r_tie;
    logic              r_rr;

    logic              w_in_valid [2];
    logic [ADDR_W-1:0] w_in_addr  [2];
    logic [DATA_W-1:0] w_in_data  [2];
    logic [1:0]        w_grant;
    logic [1:0]        w_ready;
    logic [1:0]        w_load;
    logic [1:0]        w_full_next;
    logic [1:0]        w_match;
    logic              w_both;
    logic              w_gsel;
    logic              w_younger;

    assign w_in_valid[0] = req0_valid;
    assign w_in_valid[1] = req1_valid;
    assign w_in_addr[0]  = req0_addr;
    assign w_in_addr[1]  = req1_addr;
    assign w_in_data[0]  = req0_data;
    assign w_in_data[1]  = req1_data;

    // Slots loaded on the same edge have no age order; the rr pointer breaks that tie.
    assign w_both    = &r_full;
    assign w_gsel    = w_both ? (r_tie ? r_rr : r_older) : (r_full[1] & ~r_full[0]);
    assign w_younger = r_tie ? ~r_rr : ~r_older;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            assign w_grant[gi]     = r_full[gi] & (w_gsel == 1'(gi));
            assign w_ready[gi]     = ~r_full[gi] | w_grant[gi];
            assign w_load[gi]      = w_in_valid[gi] & w_ready[gi] & (w_in_addr[gi] != '0);
            assign w_full_next[gi] = w_load[gi] | (r_full[gi] & ~w_grant[gi]);
            assign w_match[gi]     = r_full[gi] & (r_addr[gi] == q_addr) & (q_addr != '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_full[gi] <= 1'b0;
                    r_addr[gi] <= '0;
                    r_data[gi] <= '0;
                end else begin
                    r_full[gi] <= w_full_next[gi];
                    if (w_load[gi]) begin
                        r_addr[gi] <= w_in_addr[gi];
                        r_data[gi] <= w_in_data[gi];
                    end
                end
            end
        end
    endgenerate

    // A slot that reloads while the other stays full becomes the younger one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_older <= 1'b0;
            r_tie   <= 1'b0;
            r_rr    <= 1'b0;
        end else begin
            if (w_both && r_tie) begin
                r_rr <= ~r_rr;
            end
            if (&w_full_next) begin
                if (&w_load) begin
                    r_tie <= 1'b1;
                end else begin
                    r_tie <= 1'b0;
                    if (w_load[0]) begin
                        r_older <= 1'b1;
                    end else if (w_load[1]) begin
                        r_older <= 1'b0;
                    end
                end
            end else begin
                r_tie <= 1'b0;
            end
        end
    end

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];

    assign we3 = |r_full;
    assign a3  = we3 ? r_addr[w_gsel] : '0;
    assign wd3 = we3 ? r_data[w_gsel] : '0;

    always_comb begin
        q_data = '0;
        if (&w_match) begin
            q_data = r_data[w_younger];
        end else if (w_match[0]) begin
            q_data = r_data[0];
        end else if (w_match[1]) begin
            q_data = r_data[1];
        end
    end

    assign q_hit   = |w_match;
    assign pending = {1'b0, r_full[0]} + {1'b0, r_full[1]};

endmodule
